// File: rtl/alu_pkg.sv
// Shared constants for the 6-bit ALU: width, opcode encodings and flag bit positions.
package alu_pkg;

  localparam int ALU_WIDTH = 6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder for ADD and SUB: subtraction is A + ~B + 1 through the same carry chain.
module alu_addsub #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum  = w_full[WIDTH-1:0];
  assign o_cout = w_full[WIDTH];
  // Same-sign addends (after B inversion) producing a differently signed sum.
  assign o_ovf  = (i_a[WIDTH-1] == w_b[WIDTH-1]) & (w_full[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Registered 6-bit signed ALU: opcode mux and flag generation feeding one output register stage.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic signed [WIDTH-1:0] i_arg0,
  input  logic signed [WIDTH-1:0] i_arg1,
  input  logic [1:0]              i_oper,
  output logic signed [WIDTH-1:0] o_result,
  output logic [3:0]              o_flag
);

  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_v;
  logic [3:0]       w_flag;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flag;

  assign w_sub = (i_oper == OP_SUB);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a    (i_arg0),
    .i_b    (i_arg1),
    .i_sub  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovf  (w_ovf)
  );

  // Opcode mux; for SUB the adder carry-out is the inverse of the borrow.
  always_comb begin
    w_result = {WIDTH{1'b0}};
    w_carry  = 1'b0;
    w_v      = 1'b0;
    case (i_oper)
      OP_ADD: begin
        w_result = w_sum;
        w_carry  = w_cout;
        w_v      = w_ovf;
      end
      OP_SUB: begin
        w_result = w_sum;
        w_carry  = ~w_cout;
        w_v      = w_ovf;
      end
      OP_AND: begin
        w_result = i_arg0 & i_arg1;
      end
      OP_XOR: begin
        w_result = i_arg0 ^ i_arg1;
      end
      default: begin
        w_result = {WIDTH{1'b0}};
      end
    endcase
  end

  // Flag vector assembly from the selected result.
  always_comb begin
    w_flag         = 4'b0000;
    w_flag[FLAG_Z] = (w_result == {WIDTH{1'b0}});
    w_flag[FLAG_N] = w_result[WIDTH-1];
    w_flag[FLAG_C] = w_carry;
    w_flag[FLAG_V] = w_v;
  end

  // Output register stage; reset clears flags to all-zero, including Z.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= {WIDTH{1'b0}};
      r_flag   <= 4'b0000;
    end else begin
      r_result <= w_result;
      r_flag   <= w_flag;
    end
  end

  assign o_result = r_result;
  assign o_flag   = r_flag;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes model predictions, monitor pops and compares after each capturing edge.
module tb_alu;

  logic              clk;
  logic              rst_n;
  logic signed [5:0] arg0;
  logic signed [5:0] arg1;
  logic [1:0]        oper;
  logic signed [5:0] result;
  logic [3:0]        flag;

  int tests_run;
  int tests_failed;
  int seq_id;

  typedef struct {
    logic [9:0] exp;
    int         id;
  } item_t;

  item_t exp_q[$];

  alu dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_arg0   (arg0),
    .i_arg1   (arg1),
    .i_oper   (oper),
    .o_result (result),
    .o_flag   (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic, returns {V,C,N,Z,result}.
  function automatic logic [9:0] model(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
    int sa;
    int sb;
    int ua;
    int ub;
    int r;
    logic c;
    logic v;
    logic [5:0] res;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    ub = int'(b);
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      2'b00: begin r = sa + sb; c = (ua + ub) > 63; v = (r > 31) || (r < -32); end
      2'b01: begin r = sa - sb; c = ua < ub;        v = (r > 31) || (r < -32); end
      2'b10: r = int'(a & b);
      default: r = int'(a ^ b);
    endcase
    res = r[5:0];
    return {v, c, res[5], (res == 6'd0), res};
  endfunction

  task automatic drive_now(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
    item_t it;
    arg0 = a;
    arg1 = b;
    oper = op;
    if (rst_n) begin
      it.exp = model(a, b, op);
      it.id  = seq_id;
      exp_q.push_back(it);
    end
    seq_id++;
  endtask

  task automatic drive(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
    @(negedge clk);
    drive_now(a, b, op);
  endtask

  task automatic check_zero(input string name);
    tests_run++;
    if (result !== 6'sd0 || flag !== 4'b0000) begin
      tests_failed++;
      $display("FAIL %s: result=%0d flag=%b, required result=0 flag=0000", name, result, flag);
    end
  endtask

  // Monitor: after every capturing edge, compare outputs against the oldest prediction.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && exp_q.size() > 0) begin
        #1;
        it = exp_q.pop_front();
        tests_run++;
        if ({flag, result} !== it.exp) begin
          tests_failed++;
          $display("FAIL op#%0d: result=%0d flag=%b, required result=%0d flag=%b",
                   it.id, result, flag, $signed(it.exp[5:0]), it.exp[9:6]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  logic [5:0] da[8] = '{6'd17, 6'h3F, 6'd1, 6'd1, 6'h20, 6'd3, 6'd5, 6'h3F};
  logic [5:0] db[8] = '{6'd18, 6'd1,  6'd1, 6'd2, 6'd1,  6'd1, 6'd2, 6'h3F};
  logic [1:0] dop[8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    seq_id       = 0;
    rst_n = 1'b0;
    arg0  = 6'sd5;
    arg1  = 6'sd9;
    oper  = 2'b00;
    #1;
    check_zero("reset_immediate");
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_held");

    @(negedge clk);
    rst_n = 1'b1;
    drive_now(6'd2, 6'd13, 2'b00);

    // Directed vectors back-to-back, opcode and operands change every cycle.
    for (int i = 0; i < 8; i++) drive(da[i], db[i], dop[i]);

    drive(6'd2, 6'd13, 2'b00);
    @(negedge clk);
    arg0 = 6'd7;
    arg1 = 6'd7;
    oper = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midstream_async_clear");
    @(posedge clk);
    #1;
    check_zero("midstream_held");
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(6'd3, 6'd4, 2'b00);
    drive(6'h20, 6'h20, 2'b00);

    for (int i = 0; i < 300; i++)
      drive(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));

    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
